// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Forwarding-mux codes, mult/div FSM states and the register-compare rule live here.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // $zero is hardwired, so a producer writing it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Busy tracker for the multi-cycle mult/div unit.
// MdBusy rises the cycle after issue and stays high for exactly MULT_LAT or DIV_LAT cycles.
module hazard_ctrl_md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_op,
  output logic md_busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      MD_IDLE: begin
        if (md_start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = md_op ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
        end
      end
      // A start while busy is ignored here; the stall logic keeps it from happening.
      MD_BUSY: begin
        if (cnt == '0) state_nxt = MD_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = (state == MD_BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Compares D/E/M/W register addresses, tracks the mult/div unit and counts stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       RegAddrE,
  input  logic [4:0]       RegAddrM,
  input  logic [4:0]       RegAddrW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             JrD,
  input  logic             MdUseD,
  input  logic             MdStartE,
  input  logic             MdOpE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCnt
);

  logic lwstall, brstall, mdstall, stall;

  hazard_ctrl_md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (MdStartE),
    .md_op    (MdOpE),
    .md_busy  (MdBusy)
  );

  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    ForwardAE = FWD_RF;
    if (RegWriteM && reg_match(RegAddrM, RsE))      ForwardAE = FWD_MEM;
    else if (RegWriteW && reg_match(RegAddrW, RsE)) ForwardAE = FWD_WB;

    ForwardBE = FWD_RF;
    if (RegWriteM && reg_match(RegAddrM, RtE))      ForwardBE = FWD_MEM;
    else if (RegWriteW && reg_match(RegAddrW, RtE)) ForwardBE = FWD_WB;

    ForwardAD = RegWriteM && reg_match(RegAddrM, RsD);
    ForwardBD = RegWriteM && reg_match(RegAddrM, RtD);
  end

  // Branches resolve in ID, so an EX result or a MEM load is not yet available to them;
  // jr/jalr read rs only.
  always_comb begin
    lwstall = MemtoRegE && (reg_match(RegAddrE, RsD) || reg_match(RegAddrE, RtD));
    brstall = (BranchD || JrD) &&
              ((RegWriteE && (reg_match(RegAddrE, RsD) || (BranchD && reg_match(RegAddrE, RtD)))) ||
               (MemtoRegM && (reg_match(RegAddrM, RsD) || (BranchD && reg_match(RegAddrM, RtD)))));
    mdstall = MdUseD && (MdBusy || MdStartE);
    stall   = lwstall || brstall || mdstall;
    StallF  = stall;
    StallD  = stall;
    FlushE  = stall;
  end

  // NOTE: the counter is reset explicitly; debug readout must start from a known zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
    end else if (StallD && (StallCnt != '1)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors plus a per-cycle behavioural model.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = 65535;

  logic       clk;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, RegAddrE, RegAddrM, RegAddrW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, JrD, MdUseD, MdStartE, MdOpE;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCnt;

  int checks = 0;
  int errors = 0;

  // Model state: cycles of busy remaining, and the saturating stall count.
  int model_left = 0;
  int model_cnt  = 0;

  hazard_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .RegAddrE  (RegAddrE),
    .RegAddrM  (RegAddrM),
    .RegAddrW  (RegAddrW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemtoRegE (MemtoRegE),
    .MemtoRegM (MemtoRegM),
    .BranchD   (BranchD),
    .JrD       (JrD),
    .MdUseD    (MdUseD),
    .MdStartE  (MdStartE),
    .MdOpE     (MdOpE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushE    (FlushE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .MdBusy    (MdBusy),
    .StallCnt  (StallCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [4:0] producer, input logic [4:0] consumer);
    return (producer != 0) && (producer == consumer);
  endfunction

  function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
    if (RegWriteM && dep(RegAddrM, src)) return 2'b10;
    if (RegWriteW && dep(RegAddrW, src)) return 2'b01;
    return 2'b00;
  endfunction

  // A stall is needed whenever some ID consumer's value is not yet obtainable.
  function automatic bit exp_stall();
    bit uses_rs_early, uses_rt_early, hz;
    uses_rs_early = BranchD || JrD;
    uses_rt_early = BranchD;
    hz = 0;
    if (MemtoRegE && (dep(RegAddrE, RsD) || dep(RegAddrE, RtD))) hz = 1;
    if (uses_rs_early && RegWriteE && dep(RegAddrE, RsD)) hz = 1;
    if (uses_rt_early && RegWriteE && dep(RegAddrE, RtD)) hz = 1;
    if (uses_rs_early && MemtoRegM && dep(RegAddrM, RsD)) hz = 1;
    if (uses_rt_early && MemtoRegM && dep(RegAddrM, RtD)) hz = 1;
    if (MdUseD && (model_left > 0 || MdStartE)) hz = 1;
    return hz;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_left <= 0;
      model_cnt  <= 0;
    end else begin
      if (model_left > 0)  model_left <= model_left - 1;
      else if (MdStartE)   model_left <= MdOpE ? DIV_LAT : MULT_LAT;
      if (exp_stall() && model_cnt < CNT_MAX) model_cnt <= model_cnt + 1;
    end
  end

  always @(negedge clk) begin
    bit s;
    s = exp_stall();
    check("m_StallF", StallF, s);
    check("m_StallD", StallD, s);
    check("m_FlushE", FlushE, s);
    check("m_ForwardAE", ForwardAE, exp_fwd_e(RsE));
    check("m_ForwardBE", ForwardBE, exp_fwd_e(RtE));
    check("m_ForwardAD", ForwardAD, RegWriteM && dep(RegAddrM, RsD));
    check("m_ForwardBD", ForwardBD, RegWriteM && dep(RegAddrM, RtD));
    check("m_MdBusy", MdBusy, model_left > 0);
    check("m_StallCnt", StallCnt, model_cnt);
    check("m_legal_issue", MdStartE && (model_left > 0), 1'b0);
  end

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    RegAddrE = 0; RegAddrM = 0; RegAddrW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; JrD = 0; MdUseD = 0; MdStartE = 0; MdOpE = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    check("rst_StallCnt", StallCnt, 16'h0000);
    check("rst_MdBusy", MdBusy, 1'b0);
    step();
    reset = 1'b1;

    // Forwarding priority: MEM over WB.
    RegWriteM = 1; RegAddrM = 8; RsE = 8; RegWriteW = 1; RegAddrW = 8; RtE = 3;
    @(negedge clk);
    check("fwd_mem_wins", ForwardAE, 2'b10);
    check("fwd_rt_none", ForwardBE, 2'b00);
    step();
    RegWriteM = 0;
    @(negedge clk);
    check("fwd_wb", ForwardAE, 2'b01);

    // Load-use stall for one cycle.
    step(); clear_inputs();
    MemtoRegE = 1; RegAddrE = 9; RtD = 9;
    @(negedge clk);
    check("lw_stallF", StallF, 1'b1);
    check("lw_flushE", FlushE, 1'b1);
    check("lw_cnt_before", StallCnt, 16'd0);
    step(); clear_inputs();
    @(negedge clk);
    check("lw_release", StallD, 1'b0);
    check("lw_cnt_after", StallCnt, 16'd1);

    // Branch on EX result stalls; one cycle later it forwards from MEM.
    step();
    BranchD = 1; RtD = 10; RegWriteE = 1; RegAddrE = 10;
    @(negedge clk);
    check("br_stall", StallD, 1'b1);
    step(); clear_inputs();
    BranchD = 1; RtD = 10; RegWriteM = 1; RegAddrM = 10; MemtoRegM = 0;
    @(negedge clk);
    check("br_nostall", StallD, 1'b0);
    check("br_fwdBD", ForwardBD, 1'b1);
    check("br_cnt", StallCnt, 16'd2);
    step(); clear_inputs();
    JrD = 1; RtD = 11; RegWriteE = 1; RegAddrE = 11;
    @(negedge clk);
    check("jr_ignores_rt", StallD, 1'b0);

    // Divide: stall for issue cycle + 10 busy cycles, release on the 12th.
    step(); clear_inputs();
    base = 2;
    MdStartE = 1; MdOpE = 1; MdUseD = 1;
    @(negedge clk);
    check("div_issue_stall", StallD, 1'b1);
    check("div_issue_idle", MdBusy, 1'b0);
    step();
    MdStartE = 0; MdOpE = 0;
    for (int i = 0; i < DIV_LAT; i++) begin
      @(negedge clk);
      check("div_busy", MdBusy, 1'b1);
      check("div_stall", StallD, 1'b1);
      step();
    end
    @(negedge clk);
    check("div_done", MdBusy, 1'b0);
    check("div_release", StallD, 1'b0);
    check("div_cnt", StallCnt, base + 11);

    // Reset in the 3rd busy cycle of a divide, then a mult.
    step(); clear_inputs();
    MdStartE = 1; MdOpE = 1;
    step();
    MdStartE = 0; MdOpE = 0;
    step();
    step();
    #2;
    check("pre_rst_busy", MdBusy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", MdBusy, 1'b0);
    check("mid_rst_cnt", StallCnt, 16'd0);
    step();
    reset = 1'b1;
    step();
    MdStartE = 1; MdOpE = 0;
    step();
    MdStartE = 0;
    for (int i = 0; i < MULT_LAT; i++) begin
      @(negedge clk);
      check("mult_busy", MdBusy, 1'b1);
      step();
    end
    @(negedge clk);
    check("mult_done", MdBusy, 1'b0);

    // $zero never forwards; saturate the stall counter.
    step(); clear_inputs();
    RegWriteM = 1; RegAddrM = 0; RsE = 0; RsD = 0;
    @(negedge clk);
    check("zero_fwdAE", ForwardAE, 2'b00);
    check("zero_fwdAD", ForwardAD, 1'b0);
    check("sat_start", StallCnt, 16'd0);
    step(); clear_inputs();
    MemtoRegE = 1; RegAddrE = 9; RsD = 9;
    repeat (CNT_MAX - 1) @(posedge clk);
    @(negedge clk);
    check("sat_fffe", StallCnt, 16'hFFFE);
    step();
    @(negedge clk);
    check("sat_ffff", StallCnt, 16'hFFFF);
    repeat (5) step();
    @(negedge clk);
    check("sat_hold", StallCnt, 16'hFFFF);
    clear_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
